// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset. Counts lock timeouts and lock losses for diagnostics.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] loss_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          inc_timeout;
  logic          inc_loss;
  logic          sync1;
  logic          locked_s;

  assign state_o = state;

  // relock_req wins over every state-local event, so no diagnostic count moves
  // when it coincides with a timeout or a lock loss.
  always_comb begin
    next_state  = state;
    inc_timeout = 1'b0;
    inc_loss    = 1'b0;
    if (relock_req) begin
      next_state = S_PLL_RESET;
    end else begin
      case (state)
        S_PLL_RESET: begin
          if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            next_state = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            next_state  = S_PLL_RESET;
            inc_timeout = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_s)                next_state = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST)  next_state = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            next_state = S_PLL_RESET;
            inc_loss   = 1'b1;
          end
        end
        default: next_state = S_PLL_RESET;
      endcase
    end
    cnt_clr = relock_req || (next_state != state);
  end

  // Outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= S_PLL_RESET;
      cnt           <= '0;
      sync1         <= 1'b0;
      locked_s      <= 1'b0;
      pll_rst       <= 1'b1;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
      timeout_count <= '0;
      loss_count    <= '0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      state    <= next_state;
      if (cnt_clr)          cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CW'(1);
      pll_rst   <= (next_state == S_PLL_RESET);
      sys_reset <= (next_state != S_RUN);
      ready     <= (next_state == S_RUN);
      if (inc_timeout && (timeout_count != '1)) timeout_count <= timeout_count + CNT_W'(1);
      if (inc_loss && (loss_count != '1))       loss_count    <= loss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: power-up, timeouts, lock bounce,
// loss in RUN, relock priority, counter saturation and mid-run reset.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic       pll_rst, sys_reset, ready;
  logic [1:0] state_o;
  logic [7:0] timeout_count, loss_count;

  logic       rst2 = 1'b1, pll_locked2 = 1'b0, relock_req2 = 1'b0;
  logic       pll_rst2, sys_reset2, ready2;
  logic [1:0] state2;
  logic [1:0] timeout_count2, loss_count2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(.RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .CNT_W(8)) u_dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .state_o(state_o),
    .timeout_count(timeout_count), .loss_count(loss_count)
  );

  pll_reset_sequencer #(.RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .CNT_W(2)) u_sat (
    .refclk(refclk), .rst(rst2), .pll_locked(pll_locked2), .relock_req(relock_req2),
    .pll_rst(pll_rst2), .sys_reset(sys_reset2), .ready(ready2), .state_o(state2),
    .timeout_count(timeout_count2), .loss_count(loss_count2)
  );

  // Advance one edge and sample 1 ns after it.
  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic reset_main();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b exp 1", pll_rst); end
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset got %b exp 1", sys_reset); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
    n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
    n_checks++; if (timeout_count !== 8'd0) begin n_fail++; $display("FAIL reset_timeout got %0d exp 0", timeout_count); end
    n_checks++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d exp 0", loss_count); end
  endtask

  task automatic test_power_up();
    int hi;
    pll_locked = 1'b0;
    rst = 1'b0;
    cyc = 0;
    hi = (pll_rst === 1'b1) ? 1 : 0;
    while (cyc < 30) begin
      step();
      if (pll_rst === 1'b1) hi++;
      if (cyc == 1) begin
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL pu_state_c1 got %0d exp 0", state_o); end
      end
      if (cyc == 10) pll_locked = 1'b1;
      if (cyc == 20) begin
        n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL pu_sys_reset_c20 got %b exp 1", sys_reset); end
      end
      if (cyc == 21) begin
        n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL pu_sys_reset_c21 got %b exp 0", sys_reset); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL pu_ready got %b exp 1", ready); end
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL pu_state got %0d exp 3", state_o); end
      end
    end
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL pu_pll_rst_width got %0d exp 4", hi); end
  endtask

  task automatic test_no_lock();
    int bad;
    logic exp_rst;
    reset_main();
    bad = 0;
    while (cyc <= 200) begin
      exp_rst = ((cyc % 36) < 4);
      if (pll_rst !== exp_rst || sys_reset !== 1'b1) bad++;
      if (cyc == 36) begin
        n_checks++; if (timeout_count !== 8'd1) begin n_fail++; $display("FAIL nl_timeout_c36 got %0d exp 1", timeout_count); end
      end
      if (cyc == 180) begin
        n_checks++; if (timeout_count !== 8'd5) begin n_fail++; $display("FAIL nl_timeout_c180 got %0d exp 5", timeout_count); end
      end
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL nl_pattern bad_cycles %0d exp 0", bad); end
  endtask

  task automatic test_stable_bounce();
    int bad;
    reset_main();
    bad = 0;
    while (cyc < 22) begin
      step();
      if (cyc == 5)  pll_locked = 1'b1;
      if (cyc == 10) pll_locked = 1'b0;
      if (cyc == 11) pll_locked = 1'b1;
      if (cyc >= 4 && pll_rst !== 1'b0) bad++;
      if (cyc == 12) begin
        n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL sb_state_c12 got %0d exp 2", state_o); end
      end
      if (cyc == 13) begin
        n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL sb_state_c13 got %0d exp 1", state_o); end
      end
      if (cyc == 21) begin
        n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL sb_sys_reset_c21 got %b exp 1", sys_reset); end
      end
      if (cyc == 22) begin
        n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL sb_sys_reset_c22 got %b exp 0", sys_reset); end
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL sb_state_c22 got %0d exp 3", state_o); end
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sb_no_pll_rst bad_cycles %0d exp 0", bad); end
  endtask

  task automatic test_loss_in_run();
    int hi;
    hi = 0;
    while (cyc < 41) begin
      step();
      if (cyc == 25) pll_locked = 1'b0;
      if (cyc == 28) pll_locked = 1'b1;
      if (cyc >= 26 && cyc <= 40 && pll_rst === 1'b1) hi++;
      if (cyc == 27) begin
        n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL lr_sys_reset_c27 got %b exp 0", sys_reset); end
      end
      if (cyc == 28) begin
        n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL lr_sys_reset_c28 got %b exp 1", sys_reset); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL lr_ready_c28 got %b exp 0", ready); end
        n_checks++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL lr_loss got %0d exp 1", loss_count); end
        n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL lr_pll_rst_c28 got %b exp 1", pll_rst); end
      end
      if (cyc == 40) begin
        n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL lr_state_c40 got %0d exp 2", state_o); end
      end
    end
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL lr_pll_rst_width got %0d exp 4", hi); end
    n_checks++; if (state_o !== 2'd3 || ready !== 1'b1) begin n_fail++; $display("FAIL lr_recover state %0d ready %b exp 3 1", state_o, ready); end
  endtask

  task automatic test_relock_priority();
    int hi;
    hi = 0;
    while (cyc < 60) begin
      step();
      if (cyc == 45) pll_locked = 1'b0;
      if (cyc == 47) relock_req = 1'b1;
      if (cyc == 48) relock_req = 1'b0;
      if (cyc == 49) relock_req = 1'b1;
      if (cyc == 50) relock_req = 1'b0;
      if (cyc >= 48 && pll_rst === 1'b1) hi++;
      if (cyc == 47) begin
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL rp_state_c47 got %0d exp 3", state_o); end
      end
      if (cyc == 48) begin
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rp_state_c48 got %0d exp 0", state_o); end
        n_checks++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL rp_loss got %0d exp 1", loss_count); end
        n_checks++; if (timeout_count !== 8'd0) begin n_fail++; $display("FAIL rp_timeout got %0d exp 0", timeout_count); end
      end
    end
    n_checks++; if (hi != 6) begin n_fail++; $display("FAIL rp_restart_width got %0d exp 6", hi); end
  endtask

  task automatic test_saturation_and_reset();
    rst2 = 1'b1; pll_locked2 = 1'b0;
    step(); step();
    rst2 = 1'b0;
    cyc = 0;
    while (cyc < 186) begin
      step();
      if (cyc == 72) begin
        n_checks++; if (timeout_count2 !== 2'd2) begin n_fail++; $display("FAIL sat_c72 got %0d exp 2", timeout_count2); end
      end
      if (cyc == 144) begin
        n_checks++; if (timeout_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_c144 got %0d exp 3", timeout_count2); end
      end
      if (cyc == 180) begin
        n_checks++; if (timeout_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_c180 got %0d exp 3", timeout_count2); end
        pll_locked2 = 1'b1;
      end
    end
    n_checks++; if (state2 !== 2'd2) begin n_fail++; $display("FAIL sat_stable got %0d exp 2", state2); end
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    n_checks++; if (state2 !== 2'd0) begin n_fail++; $display("FAIL mr_state got %0d exp 0", state2); end
    n_checks++; if (pll_rst2 !== 1'b1 || sys_reset2 !== 1'b1 || ready2 !== 1'b0)
      begin n_fail++; $display("FAIL mr_outputs pll_rst %b sys_reset %b ready %b exp 1 1 0", pll_rst2, sys_reset2, ready2); end
    n_checks++; if (timeout_count2 !== 2'd0 || loss_count2 !== 2'd0)
      begin n_fail++; $display("FAIL mr_counts timeout %0d loss %0d exp 0 0", timeout_count2, loss_count2); end
    step();
    n_checks++; if (state2 !== 2'd0 || pll_rst2 !== 1'b1 || sys_reset2 !== 1'b1)
      begin n_fail++; $display("FAIL mr_after state %0d pll_rst %b sys_reset %b exp 0 1 1", state2, pll_rst2, sys_reset2); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_no_lock();
    test_stable_bounce();
    test_loss_in_run();
    test_relock_priority();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
